uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that sits directly downstream of the UART transmitter on the far end of the serial link. It samples the asynchronous `rx_pin` line and recovers 8N1 frames: one start bit, 8 data bits LSB first, one stop bit. Each good byte is presented on a valid/ready byte interface with a one-deep output register. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLK_FRE`, 50, clock frequency in MHz
- `BAUD_RATE`, 115200, serial baud rate; `CYCLE = CLK_FRE*1000000/BAUD_RATE` clocks per bit (434 at defaults)
- `clk` input 1 — single clock, all logic on its rising edge
- `rst` input 1 — asynchronous, active-high reset
- `rx_pin` input 1 — asynchronous serial line, idle high
- `rx_data` output 8 — received byte, stable while `rx_data_valid`=1
- `rx_data_valid` output 1 — byte available
- `rx_data_ready` input 1 — consumer accepts; transfer occurs when valid & ready are high at a rising edge
- `rx_frame_err` output 1 — one-cycle pulse: stop bit sampled low
- `rx_overrun` output 1 — one-cycle pulse: good byte completed while the output register was still full

## Operation
- Input sync: two-flop synchronizer on `rx_pin`, both stages reset to 1. An edge register holds the previous synced value, also reset to 1. A falling edge is previous=1 & synced=0.
- Counters: `cycle_cnt` is 32 bits, wide enough for any CYCLE. `bit_cnt` is 3 bits. `shift` is 8 bits.
- States: S_IDLE, S_START, S_REC_BIT, S_STOP. Reset enters S_IDLE.
- S_IDLE: `cycle_cnt`=0. A falling edge moves to S_START.
- S_START: count up. At `cycle_cnt`==CYCLE/2-1 (integer division), sample the synced line:
  - 0 → go to S_REC_BIT with `cycle_cnt`=0 and `bit_cnt`=0.
  - 1 → false start; go to S_IDLE.
- S_REC_BIT: at `cycle_cnt`==CYCLE-1, store the synced line into `shift[bit_cnt]` and clear `cycle_cnt`. This samples at mid-bit.
  - `bit_cnt`==7 → go to S_STOP.
  - Otherwise increment `bit_cnt`.
- S_STOP: at `cycle_cnt`==CYCLE-1, sample the stop bit and always go to S_IDLE, i.e. mid-stop-bit, to resync on the next start edge.
  - Sample 1 → good byte.
  - Sample 0 → `rx_frame_err` pulse; byte discarded.
- Break handling: a line held low after a frame error does not retrigger, because S_IDLE requires a fresh falling edge.
- Output register, when a good byte completes:
  - `rx_data_valid`=0, or valid & ready in the same cycle → load `shift` into `rx_data` and set valid.
  - Otherwise → pulse `rx_overrun`; `rx_data` and valid are unchanged, and the new byte is dropped.
- Consumption: valid & ready with no completion in the same cycle clears valid. `rx_data` holds its last value.

## Timing
- Reset values: `rx_data`=0x00, `rx_data_valid`=0, `rx_frame_err`=0, `rx_overrun`=0, state S_IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately. After release, a new falling edge is needed; a line already low is ignored until it returns high and falls again.
- Input latency: 2 clocks synchronizer + 1 clock edge detect from a pin change to S_START entry.
- Stop-bit sample time: the pin falling edge + CYCLE/2 + 9*CYCLE + 3 clocks (±1).
- Output timing: `rx_data_valid` rises on the clock edge after the stop sample. Error pulses occur on that same edge and are exactly 1 cycle wide.
- Glitch rejection: a low pulse shorter than about CYCLE/2 is rejected as a false start.
- Baud tolerance: mid-bit sampling tolerates ±4% baud mismatch.
- Throughput: back-to-back frames (next start bit right after the stop bit) are received with no loss, given ready is high. S_IDLE is re-entered half a bit before the next start edge.

## Test plan
- Reset, then send 0x55 at the nominal CYCLE with `rx_data_ready`=1 → a single valid cycle with `rx_data`=0x55; no error pulses.
- Send back-to-back 0xA3, 0x0F, 0xFF, 0x00 with no idle gap and ready=1 → four valid handshakes in order with those values.
- Drive a low glitch of CYCLE/4 clocks on an idle line → no valid, no error; a following 0x3C is still received correctly.
- Send 0x81 with the stop bit driven 0 → one `rx_frame_err` pulse, no valid. Hold the line low 20*CYCLE, then release → no further frames or errors.
- Hold ready=0 and send 0x12 then 0x34 → valid stays high with `rx_data`=0x12, and one `rx_overrun` pulse at the second stop sample. Raise ready → valid drops after one transfer.
- Assert `rst` during bit 4 of 0x99, release mid-frame → outputs return to reset values, no spurious byte. The next full frame 0x66 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input sync, mid-bit sampling FSM and a one-deep
// valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int          CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [31:0] BIT_LAST  = 32'(CYCLE - 1);
  localparam logic [31:0] HALF_LAST = 32'(CYCLE / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_REC_BIT = 2'd2,
    S_STOP    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        sync1;
  logic        sync2;
  logic        prev;
  logic        fall;
  logic [31:0] cycle_cnt;
  logic [31:0] cycle_cnt_next;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        byte_done;
  logic        frame_err;

  // Synchronizer and edge register; resetting to 1 means a low line needs a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall = prev & ~sync2;

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cycle_cnt <= 32'd0;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
    end else begin
      state     <= state_next;
      cycle_cnt <= cycle_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
    end
  end

  // Next-state logic: half-bit wait in S_START, then sample every full bit.
  always_comb begin
    state_next     = state;
    cycle_cnt_next = cycle_cnt;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    byte_done      = 1'b0;
    frame_err      = 1'b0;
    case (state)
      S_IDLE: begin
        cycle_cnt_next = 32'd0;
        if (fall) begin
          state_next = S_START;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_START: begin
        if (cycle_cnt == HALF_LAST) begin
          cycle_cnt_next = 32'd0;
          bit_cnt_next   = 3'd0;
          if (!sync2) begin
            state_next = S_REC_BIT;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cycle_cnt_next = cycle_cnt + 32'd1;
        end
      end
      S_REC_BIT: begin
        if (cycle_cnt == BIT_LAST) begin
          cycle_cnt_next      = 32'd0;
          shift_next[bit_cnt] = sync2;
          if (bit_cnt == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end else begin
          cycle_cnt_next = cycle_cnt + 32'd1;
        end
      end
      S_STOP: begin
        if (cycle_cnt == BIT_LAST) begin
          cycle_cnt_next = 32'd0;
          state_next     = S_IDLE;
          if (sync2) begin
            byte_done = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          cycle_cnt_next = cycle_cnt + 32'd1;
        end
      end
      default: begin
        state_next     = S_IDLE;
        cycle_cnt_next = 32'd0;
      end
    endcase
  end

  // One-deep output register; a byte arriving while it is full and not draining is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_frame_err <= frame_err;
      rx_overrun   <= byte_done & rx_data_valid & ~rx_data_ready;
      if (byte_done && (!rx_data_valid || rx_data_ready)) begin
        rx_data       <= shift;
        rx_data_valid <= 1'b1;
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end else begin
        rx_data_valid <= rx_data_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a monitor pops
// them on each valid/ready transfer and counts error pulses.
module tb_uart_rx;
  localparam int CYC = 16;  // CLK_FRE=1, BAUD_RATE=62500

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready = 1'b1;
  logic       rx_frame_err;
  logic       rx_overrun;

  int total = 0;
  int bad = 0;
  int exp_ferr = 0;
  int exp_ovr = 0;
  int ferr_seen = 0;
  int ovr_seen = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_FRE(1), .BAUD_RATE(62500)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  function automatic void cmp(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // Monitor: pulse counting (each high cycle counts, so wide pulses show up) and byte checks.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_frame_err) ferr_seen++;
      if (rx_overrun) ovr_seen++;
      if (rx_data_valid && rx_data_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none", rx_data);
        end else begin
          cmp("byte", int'(rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx_pin = v;
    repeat (CYC) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkpoint(input string name);
    cmp({name, "_pending"}, exp_q.size(), 0);
    cmp({name, "_ferr"}, ferr_seen, exp_ferr);
    cmp({name, "_ovr"}, ovr_seen, exp_ovr);
  endtask

  task automatic check_reset_outputs(input string name);
    cmp({name, "_data"}, int'(rx_data), 0);
    cmp({name, "_valid"}, int'(rx_data_valid), 0);
    cmp({name, "_ferr_out"}, int'(rx_frame_err), 0);
    cmp({name, "_ovr_out"}, int'(rx_overrun), 0);
  endtask

  initial begin
    logic [7:0] v99;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(CYC);

    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(2 * CYC);
    checkpoint("single_55");

    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(2 * CYC);
    checkpoint("back_to_back");

    rx_pin = 1'b0;
    repeat (CYC / 4) @(posedge clk);
    #1;
    idle(3 * CYC);
    checkpoint("glitch");
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    idle(2 * CYC);
    checkpoint("after_glitch");

    exp_ferr++;
    send_byte(8'h81, 1'b0);
    rx_pin = 1'b0;
    repeat (20 * CYC) @(posedge clk);
    #1;
    idle(3 * CYC);
    checkpoint("frame_err_break");

    rx_data_ready = 1'b0;
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    exp_ovr++;
    send_byte(8'h34, 1'b1);
    idle(CYC);
    cmp("held_valid", int'(rx_data_valid), 1);
    cmp("held_data", int'(rx_data), 8'h12);
    cmp("overrun_count", ovr_seen, exp_ovr);
    rx_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("valid_drained", int'(rx_data_valid), 0);
    checkpoint("overrun");

    v99 = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v99[i]);
    rx_pin = v99[4];
    repeat (CYC / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(12 * CYC);
    check_reset_outputs("post_reset");
    checkpoint("post_reset");
    exp_q.push_back(8'h66);
    send_byte(8'h66, 1'b1);
    idle(2 * CYC);
    checkpoint("after_reset_66");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
